// File: rtl/scarv_cop_rng_ctrl_if.sv
// Requester A/B handshake and RNG source signals for the SCARV coprocessor RNG controller.
// master = requesters plus RNG source (environment), slave = the controller.
interface scarv_cop_rng_ctrl_if;
    logic        a_req;
    logic        a_seed;
    logic [31:0] a_wdata;
    logic        a_ack;
    logic [31:0] a_rdata;
    logic        b_req;
    logic        b_ack;
    logic [31:0] b_rdata;
    logic        src_seed_en;
    logic [31:0] src_seed;
    logic        src_step;
    logic [31:0] src_value;

    modport master (
        output a_req, a_seed, a_wdata, b_req, src_value,
        input  a_ack, a_rdata, b_ack, b_rdata, src_seed_en, src_seed, src_step
    );

    modport slave (
        input  a_req, a_seed, a_wdata, b_req, src_value,
        output a_ack, a_rdata, b_ack, b_rdata, src_seed_en, src_seed, src_step
    );
endinterface

// File: rtl/scarv_cop_rng_ctrl.sv
// Arbitrates two requesters onto a single RNG source: A may seed or sample, B only samples
// and is held off once the source has served RESEED_INTERVAL samples since the last seed.
module scarv_cop_rng_ctrl #(
    parameter int RESEED_INTERVAL = 1024,
    parameter int CNT_W           = 16
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    scarv_cop_rng_ctrl_if.slave  rng,
    output logic                 stale,
    output logic                 busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SAMP   = 2'd1;
    localparam logic [1:0] SEED   = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    localparam logic [CNT_W-1:0] INTERVAL = CNT_W'(RESEED_INTERVAL);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      a_rdata_q, a_rdata_d;
    logic [31:0]      b_rdata_q, b_rdata_d;

    logic inIdle;
    logic eligA;
    logic eligB;
    logic grantA;
    logic grantB;
    logic seedGrant;
    logic sampleGrant;

    // Grants are combinational in the IDLE cycle; gating with reset keeps the
    // source strobes quiet while reset is held even if a request is pending.
    assign inIdle      = (state_q == IDLE) && g_resetn;
    assign eligA       = rng.a_req;
    assign eligB       = rng.b_req && !stale;
    assign grantA      = inIdle && eligA && (!eligB || (last_q == GNT_B));
    assign grantB      = inIdle && eligB && (!eligA || (last_q == GNT_A));
    assign seedGrant   = grantA && rng.a_seed;
    assign sampleGrant = (grantA && !rng.a_seed) || grantB;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        count_d   = count_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (seedGrant) begin
                    state_d = SEED;
                end else if (sampleGrant) begin
                    state_d = SAMP;
                end
            end
            SAMP:    state_d = IDLE;
            SEED:    state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (grantA) begin
            last_d = GNT_A;
        end
        if (grantB) begin
            last_d = GNT_B;
        end

        // Counter saturates at the interval so stale stays asserted until a reseed.
        if (seedGrant) begin
            count_d = '0;
        end else if (sampleGrant && (count_q != INTERVAL)) begin
            count_d = count_q + CNT_W'(1);
        end

        if (grantA && !rng.a_seed) begin
            a_rdata_d = rng.src_value;
        end
        if (seedGrant) begin
            a_rdata_d = '0;
        end
        if (grantB) begin
            b_rdata_d = rng.src_value;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= IDLE;
            last_q    <= GNT_B;
            count_q   <= INTERVAL;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            count_q   <= count_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // last_q doubles as the owner of the in-flight transaction, since it is
    // updated on every grant and no new grant happens until the ack.
    assign rng.a_ack       = ((state_q == SAMP) && (last_q == GNT_A)) || (state_q == SETTLE);
    assign rng.b_ack       = (state_q == SAMP) && (last_q == GNT_B);
    assign rng.a_rdata     = a_rdata_q;
    assign rng.b_rdata     = b_rdata_q;
    assign rng.src_seed_en = seedGrant;
    assign rng.src_seed    = rng.a_wdata;
    assign rng.src_step    = sampleGrant || (state_q == SEED);

    assign stale = (count_q == INTERVAL);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_scarv_cop_rng_ctrl.sv
// Self-checking bench for scarv_cop_rng_ctrl: scenario tasks push expected acks to a
// scoreboard queue at grant time; a negedge monitor pops and compares them on each ack.
module tb_scarv_cop_rng_ctrl;

    typedef struct packed {
        logic        isB;
        logic [31:0] data;
    } ackExp_t;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b1;
    logic stale;
    logic busy;

    ackExp_t expQ[$];
    ackExp_t monExp;
    logic [31:0] monData;

    int checkCount = 0;
    int errorCount = 0;

    scarv_cop_rng_ctrl_if rngIf ();

    scarv_cop_rng_ctrl #(
        .RESEED_INTERVAL (4),
        .CNT_W           (8)
    ) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .rng      (rngIf),
        .stale    (stale),
        .busy     (busy)
    );

    always #5 g_clk = ~g_clk;

    // Scoreboard monitor: every ack must match the oldest expected transaction.
    always @(negedge g_clk) begin
        checkCount++;
        if (rngIf.src_seed_en && rngIf.src_step) begin
            errorCount++;
            $display("[TB] FAIL srcExclusive: seed_en=%0b step=%0b, required not both 1",
                     rngIf.src_seed_en, rngIf.src_step);
        end
        if (rngIf.a_ack || rngIf.b_ack) begin
            checkCount++;
            if (expQ.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL unexpectedAck: a_ack=%0b b_ack=%0b, required no ack",
                         rngIf.a_ack, rngIf.b_ack);
            end else begin
                monExp  = expQ.pop_front();
                monData = monExp.isB ? rngIf.b_rdata : rngIf.a_rdata;
                if ({rngIf.b_ack, rngIf.a_ack} !== (monExp.isB ? 2'b10 : 2'b01)) begin
                    errorCount++;
                    $display("[TB] FAIL ackOwner: {b_ack,a_ack}=%b, required %b",
                             {rngIf.b_ack, rngIf.a_ack}, (monExp.isB ? 2'b10 : 2'b01));
                end
                checkCount++;
                if (monData !== monExp.data) begin
                    errorCount++;
                    $display("[TB] FAIL ackData: rdata=%h, required %h", monData, monExp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
        rngIf.src_value = $urandom;
    endtask

    task automatic test_reset();
        g_resetn      = 1'b0;
        rngIf.a_req   = 1'b1;
        rngIf.a_seed  = 1'b0;
        rngIf.b_req   = 1'b1;
        repeat (2) @(negedge g_clk);
        checkCount++;
        if ({busy, stale} !== 2'b01) begin
            errorCount++;
            $display("[TB] FAIL resetState: {busy,stale}=%b, required 01", {busy, stale});
        end
        checkCount++;
        if ({rngIf.src_step, rngIf.src_seed_en, rngIf.a_ack, rngIf.b_ack} !== 4'b0000) begin
            errorCount++;
            $display("[TB] FAIL resetStrobes: {step,seed_en,a_ack,b_ack}=%b, required 0000",
                     {rngIf.src_step, rngIf.src_seed_en, rngIf.a_ack, rngIf.b_ack});
        end
        checkCount++;
        if ({rngIf.a_rdata, rngIf.b_rdata} !== 64'd0) begin
            errorCount++;
            $display("[TB] FAIL resetRdata: a=%h b=%h, required 0", rngIf.a_rdata, rngIf.b_rdata);
        end
        rngIf.a_req = 1'b0;
        @(posedge g_clk);
        #2 g_resetn = 1'b1;
    endtask

    task automatic test_b_blocked_when_stale();
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge g_clk);
            checkCount++;
            if ({rngIf.b_ack, stale, busy, rngIf.src_step} !== 4'b0100) begin
                errorCount++;
                $display("[TB] FAIL staleHoldB[%0d]: {b_ack,stale,busy,step}=%b, required 0100",
                         i, {rngIf.b_ack, stale, busy, rngIf.src_step});
            end
        end
        rngIf.b_req = 1'b0;
    endtask

    task automatic test_seed(input logic [31:0] wdata);
        tick();
        rngIf.a_req   = 1'b1;
        rngIf.a_seed  = 1'b1;
        rngIf.a_wdata = wdata;
        @(negedge g_clk);
        checkCount++;
        if ({rngIf.src_seed_en, rngIf.src_step, busy} !== 3'b100 || rngIf.src_seed !== wdata) begin
            errorCount++;
            $display("[TB] FAIL seedGrant: {seed_en,step,busy}=%b seed=%h, required 100 %h",
                     {rngIf.src_seed_en, rngIf.src_step, busy}, rngIf.src_seed, wdata);
        end
        expQ.push_back('{1'b0, 32'd0});
        tick();
        @(negedge g_clk);
        checkCount++;
        if ({rngIf.src_seed_en, rngIf.src_step, busy} !== 3'b011) begin
            errorCount++;
            $display("[TB] FAIL seedDiscard: {seed_en,step,busy}=%b, required 011",
                     {rngIf.src_seed_en, rngIf.src_step, busy});
        end
        tick();
        @(negedge g_clk);
        checkCount++;
        if ({rngIf.a_ack, stale} !== 2'b10) begin
            errorCount++;
            $display("[TB] FAIL seedAck: {a_ack,stale}=%b, required 10", {rngIf.a_ack, stale});
        end
        tick();
        rngIf.a_req  = 1'b0;
        rngIf.a_seed = 1'b0;
    endtask

    // Both requesters held high; the seed made A the last grantee, so B wins the first tie.
    task automatic test_round_robin();
        logic expB;
        expB = 1'b1;
        tick();
        rngIf.a_req  = 1'b1;
        rngIf.a_seed = 1'b0;
        rngIf.b_req  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick();
            @(negedge g_clk);
            checkCount++;
            if ((i % 2) == 0) begin
                if ({rngIf.src_step, busy} !== 2'b10) begin
                    errorCount++;
                    $display("[TB] FAIL rrGrant[%0d]: {step,busy}=%b, required 10",
                             i, {rngIf.src_step, busy});
                end
                expQ.push_back('{expB, rngIf.src_value});
                expB = ~expB;
            end else if ({rngIf.src_step, busy} !== 2'b01) begin
                errorCount++;
                $display("[TB] FAIL rrAckCycle[%0d]: {step,busy}=%b, required 01",
                         i, {rngIf.src_step, busy});
            end
        end
        checkCount++;
        if (stale !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL rrStale: stale=%0b, required 1", stale);
        end
        tick();
        rngIf.a_req = 1'b0;
        rngIf.b_req = 1'b0;
    endtask

    task automatic test_stale_saturate();
        tick();
        rngIf.b_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick();
            @(negedge g_clk);
            if ((i % 2) == 0) expQ.push_back('{1'b1, rngIf.src_value});
            if (i >= 6) begin
                checkCount++;
                if (stale !== (i == 7)) begin
                    errorCount++;
                    $display("[TB] FAIL staleEdge[%0d]: stale=%0b, required %0b", i, stale, (i == 7));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge g_clk);
            checkCount++;
            if ({rngIf.src_step, busy, rngIf.b_ack} !== 3'b000) begin
                errorCount++;
                $display("[TB] FAIL staleBlocksB[%0d]: {step,busy,b_ack}=%b, required 000",
                         i, {rngIf.src_step, busy, rngIf.b_ack});
            end
        end
        tick();
        rngIf.a_req  = 1'b1;
        rngIf.a_seed = 1'b0;
        @(negedge g_clk);
        checkCount++;
        if (rngIf.src_step !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL staleAGrant: step=%0b, required 1", rngIf.src_step);
        end
        expQ.push_back('{1'b0, rngIf.src_value});
        tick();
        @(negedge g_clk);
        checkCount++;
        if ({rngIf.a_ack, stale} !== 2'b11) begin
            errorCount++;
            $display("[TB] FAIL staleAAck: {a_ack,stale}=%b, required 11", {rngIf.a_ack, stale});
        end
        tick();
        rngIf.a_req = 1'b0;
        rngIf.b_req = 1'b0;
    endtask

    task automatic test_reset_mid_seed();
        tick();
        rngIf.a_req   = 1'b1;
        rngIf.a_seed  = 1'b1;
        rngIf.a_wdata = 32'hCAFEF00D;
        @(negedge g_clk);
        checkCount++;
        if (rngIf.src_seed_en !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL midSeedGrant: seed_en=%0b, required 1", rngIf.src_seed_en);
        end
        tick();
        #1;
        checkCount++;
        if ({busy, rngIf.src_step} !== 2'b11) begin
            errorCount++;
            $display("[TB] FAIL midSeedState: {busy,step}=%b, required 11", {busy, rngIf.src_step});
        end
        g_resetn = 1'b0;
        #1;
        checkCount++;
        if ({busy, rngIf.src_step, rngIf.src_seed_en, rngIf.a_ack, stale} !== 5'b00001 ||
            {rngIf.a_rdata, rngIf.b_rdata} !== 64'd0) begin
            errorCount++;
            $display("[TB] FAIL midSeedReset: {busy,step,seed_en,a_ack,stale}=%b a=%h b=%h, required 00001 0 0",
                     {busy, rngIf.src_step, rngIf.src_seed_en, rngIf.a_ack, stale},
                     rngIf.a_rdata, rngIf.b_rdata);
        end
        repeat (2) @(posedge g_clk);
        #2;
        rngIf.a_req  = 1'b0;
        rngIf.a_seed = 1'b0;
        g_resetn     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge g_clk);
            checkCount++;
            if ({rngIf.a_ack, busy, stale} !== 3'b001) begin
                errorCount++;
                $display("[TB] FAIL postReset[%0d]: {a_ack,busy,stale}=%b, required 001",
                         i, {rngIf.a_ack, busy, stale});
            end
        end
    endtask

    initial begin
        rngIf.a_req     = 1'b0;
        rngIf.a_seed    = 1'b0;
        rngIf.a_wdata   = 32'd0;
        rngIf.b_req     = 1'b0;
        rngIf.src_value = 32'h0BAD_F00D;
        #1;
        test_reset();
        rngIf.b_req = 1'b1;
        test_b_blocked_when_stale();
        test_seed(32'hDEADBEEF);
        test_round_robin();
        test_seed(32'h1234_5678);
        test_stale_saturate();
        test_reset_mid_seed();
        repeat (2) tick();
        checkCount++;
        if (expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL pendingAcks: outstanding=%0d, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
